// File: rtl/pe_acc_pkg.sv
// Shared constants, FSM state type and term helper for the PE shift-accumulator.
package pe_acc_pkg;
  localparam int PE_SUM_W      = 10;
  localparam int ACC_W_DEF     = 24;
  localparam int SHIFT_W_DEF   = 4;
  localparam int MAX_SHIFT_DEF = 12;
  localparam int CNT_W_DEF     = 8;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  // Default-width term: sign-extend, shift by slice significance, zero if the shift is illegal.
  function automatic logic [ACC_W_DEF-1:0] sext_shift(
    input logic [PE_SUM_W-1:0]    pe_sum,
    input logic [SHIFT_W_DEF-1:0] shift
  );
    logic [ACC_W_DEF-1:0] wide;
    wide = {{(ACC_W_DEF-PE_SUM_W){pe_sum[PE_SUM_W-1]}}, pe_sum};
    if (32'(shift) > MAX_SHIFT_DEF) return '0;
    return wide << shift;
  endfunction
endpackage

// File: rtl/pe_shift_accumulator_term.sv
// Combinational term generator: sign-extend a PE partial, shift it, and flag illegal shifts.
module pe_acc_term
  import pe_acc_pkg::*;
#(
  parameter int ACC_W     = ACC_W_DEF,
  parameter int SHIFT_W   = SHIFT_W_DEF,
  parameter int MAX_SHIFT = MAX_SHIFT_DEF
) (
  input  logic [PE_SUM_W-1:0] pe_sum,
  input  logic [SHIFT_W-1:0]  shift,
  output logic [ACC_W-1:0]    term,
  output logic                illegal
);
  logic [ACC_W-1:0] wide;

  assign wide    = {{(ACC_W-PE_SUM_W){pe_sum[PE_SUM_W-1]}}, pe_sum};
  assign illegal = 32'(shift) > MAX_SHIFT;
  // An illegal beat still flows through the handshake but adds nothing.
  assign term    = illegal ? '0 : (wide << shift);
endmodule

// File: rtl/pe_shift_accumulator.sv
// Shift-and-accumulate consumer of the PE adder-tree stream with valid/ready in and out.
// Define PE_ACC_SAT_EN for saturating accumulation and the acc_sat output.
module pe_shift_accumulator
  import pe_acc_pkg::*;
#(
  parameter int ACC_W     = ACC_W_DEF,
  parameter int SHIFT_W   = SHIFT_W_DEF,
  parameter int MAX_SHIFT = MAX_SHIFT_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PE_SUM_W-1:0] pe_sum,
  input  logic [SHIFT_W-1:0]  in_shift,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_W-1:0]    acc_out,
  output logic [CNT_W-1:0]    beat_cnt,
  output logic                err_shift,
`ifdef PE_ACC_SAT_EN
  output logic                acc_sat,
`endif
  input  logic                clr_err
);
  state_t           state_reg;
  logic [ACC_W-1:0] acc_reg, acc_out_reg, term, sum;
  logic [CNT_W-1:0] cnt_reg, beat_cnt_reg, cnt_inc;
  logic             out_valid_reg, err_reg, illegal, beat;

  pe_acc_term #(
    .ACC_W     (ACC_W),
    .SHIFT_W   (SHIFT_W),
    .MAX_SHIFT (MAX_SHIFT)
  ) u_term (
    .pe_sum  (pe_sum),
    .shift   (in_shift),
    .term    (term),
    .illegal (illegal)
  );

  assign in_ready  = !out_valid_reg || out_ready;
  assign beat      = in_valid && in_ready;
  assign cnt_inc   = (&cnt_reg) ? cnt_reg : cnt_reg + 1'b1;
  assign out_valid = out_valid_reg;
  assign acc_out   = acc_out_reg;
  assign beat_cnt  = beat_cnt_reg;
  assign err_shift = err_reg;

`ifdef PE_ACC_SAT_EN
  logic [ACC_W:0] sum_ext;
  logic           ovf, sat_now, sat_run_reg, acc_sat_reg;

  assign sum_ext = {acc_reg[ACC_W-1], acc_reg} + {term[ACC_W-1], term};
  assign ovf     = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
  assign sat_now = sat_run_reg || ovf;
  assign acc_sat = acc_sat_reg;

  // Once clamped, the running sum ignores further terms until the result leaves.
  always_comb begin
    sum = sum_ext[ACC_W-1:0];
    if (sat_run_reg)
      sum = acc_reg;
    else if (ovf)
      sum = sum_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  end
`else
  // acc_reg is zero outside ACCUM, so one adder serves every state.
  assign sum = acc_reg + term;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      acc_out_reg   <= '0;
      beat_cnt_reg  <= '0;
      out_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
`ifdef PE_ACC_SAT_EN
      sat_run_reg   <= 1'b0;
      acc_sat_reg   <= 1'b0;
`endif
    end else begin
      if (beat && illegal)
        err_reg <= 1'b1;
      else if (clr_err)
        err_reg <= 1'b0;

      if (state_reg == HOLD && out_ready) begin
        out_valid_reg <= 1'b0;
        state_reg     <= IDLE;
`ifdef PE_ACC_SAT_EN
        acc_sat_reg   <= 1'b0;
`endif
      end

      // A beat may arrive in IDLE, ACCUM, or HOLD while the result is being consumed.
      if (beat) begin
        if (in_last) begin
          acc_out_reg   <= sum;
          beat_cnt_reg  <= cnt_inc;
          out_valid_reg <= 1'b1;
          acc_reg       <= '0;
          cnt_reg       <= '0;
          state_reg     <= HOLD;
`ifdef PE_ACC_SAT_EN
          acc_sat_reg   <= sat_now;
          sat_run_reg   <= 1'b0;
`endif
        end else begin
          acc_reg       <= sum;
          cnt_reg       <= cnt_inc;
          state_reg     <= ACCUM;
`ifdef PE_ACC_SAT_EN
          sat_run_reg   <= sat_now;
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_pe_shift_accumulator.sv
// Self-checking bench for pe_shift_accumulator: directed table, corner sequences, random vs. model.
module tb_pe_shift_accumulator;
  localparam int ACC_W     = 24;
  localparam int CNT_W     = 8;
  localparam int MAX_SHIFT = 12;
  localparam longint SMAX  = (longint'(1) << (ACC_W-1)) - 1;
  localparam longint SMIN  = -(longint'(1) << (ACC_W-1));

  logic             clk = 1'b0;
  logic             rst_n, in_valid, in_ready, in_last, out_valid, out_ready;
  logic             err_shift, clr_err;
  logic [9:0]       pe_sum;
  logic [3:0]       in_shift;
  logic [ACC_W-1:0] acc_out;
  logic [CNT_W-1:0] beat_cnt;
`ifdef PE_ACC_SAT_EN
  logic             acc_sat;
`endif

  always #5 clk = ~clk;

  pe_shift_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pe_sum    (pe_sum),
    .in_shift  (in_shift),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_out   (acc_out),
    .beat_cnt  (beat_cnt),
    .err_shift (err_shift),
`ifdef PE_ACC_SAT_EN
    .acc_sat   (acc_sat),
`endif
    .clr_err   (clr_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint wrap(input longint v);
    longint m;
    m = v & ((longint'(1) << ACC_W) - 1);
    if (m > SMAX) m = m - (longint'(1) << ACC_W);
    return m;
  endfunction

  function automatic longint acc_s();
    return longint'($signed(acc_out));
  endfunction

  // Reference result: plain sum of the accepted terms, wrapped or sticky-clamped.
  function automatic longint model_result(input longint terms[$], output bit sat);
    longint s;
    s   = 0;
    sat = 0;
    foreach (terms[i]) begin
`ifdef PE_ACC_SAT_EN
      if (!sat) begin
        s = s + terms[i];
        if (s > SMAX) begin s = SMAX; sat = 1; end
        else if (s < SMIN) begin s = SMIN; sat = 1; end
      end
`else
      s = s + terms[i];
`endif
    end
    return wrap(s);
  endfunction

  task automatic drive(input int ps, input int sh, input bit last, input bit v);
    in_valid = v;
    pe_sum   = 10'(ps);
    in_shift = 4'(sh);
    in_last  = last;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int     ps;
    int     sh;
    bit     last;
    longint exp_acc;
    int     exp_cnt;
    bit     exp_err;
    bit     exp_sat;
  } vec_t;

  vec_t   tbl[$];
  longint ovf_exp;
  bit     ovf_sat;

  initial begin
    rst_n = 1'b0; out_ready = 1'b1; clr_err = 1'b0;
    drive(0, 0, 0, 0);

`ifdef PE_ACC_SAT_EN
    ovf_exp = 8388607; ovf_sat = 1;
`else
    ovf_exp = -32768;  ovf_sat = 0;
`endif
    tbl.push_back('{-1, 4, 1, -16, 1, 0, 0});
    tbl.push_back('{5, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{-3, 2, 0, 0, 0, 0, 0});
    tbl.push_back('{7, 4, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 6, 1, 169, 4, 0, 0});
    for (int i = 0; i < 8; i++)
      tbl.push_back('{511, 12, (i == 7), ovf_exp, 8, 0, ovf_sat});
    tbl.push_back('{100, 13, 1, 0, 1, 1, 0});

    // Reset state
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_acc_out", acc_s(), 0);
    rst_n = 1'b1;
    tick();
    chk("rst_beat_cnt", beat_cnt, 0);
    chk("rst_err", err_shift, 0);
    chk("rst_in_ready", in_ready, 1);

    // Directed table
    foreach (tbl[i]) begin
      drive(tbl[i].ps, tbl[i].sh, tbl[i].last, 1);
      tick();
      drive(0, 0, 0, 0);
      chk("tbl_out_valid", out_valid, longint'(tbl[i].last));
      if (tbl[i].last) begin
        chk("tbl_acc", acc_s(), tbl[i].exp_acc);
        chk("tbl_cnt", beat_cnt, tbl[i].exp_cnt);
`ifdef PE_ACC_SAT_EN
        chk("tbl_sat", acc_sat, longint'(tbl[i].exp_sat));
`endif
        $display("vec %0d result acc=%0d cnt=%0d", i, acc_s(), beat_cnt);
        tick();
        chk("tbl_pulse", out_valid, 0);
      end
      chk("tbl_err", err_shift, longint'(tbl[i].exp_err));
    end

    // Sticky error, clear, and set-wins-over-clear
    tick(); tick();
    chk("err_sticky", err_shift, 1);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("err_clr", err_shift, 0);
    drive(5, 14, 1, 1); clr_err = 1'b1; tick();
    drive(0, 0, 0, 0); clr_err = 1'b0;
    chk("err_set_wins", err_shift, 1);
    chk("illegal_acc", acc_s(), 0);
    $display("illegal beat with clr: acc=%0d err=%0d", acc_s(), err_shift);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("err_clr2", err_shift, 0);

    // Back-pressure: held result, blocked beat, then release with simultaneous beat
    out_ready = 1'b0;
    drive(3, 1, 1, 1); tick();
    drive(2, 0, 1, 1);
    for (int c = 0; c < 5; c++) begin
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_acc", acc_s(), 6);
      tick();
    end
    out_ready = 1'b1; #1;
    chk("bp_release_ready", in_ready, 1);
    tick(); drive(0, 0, 0, 0);
    chk("bp_next_valid", out_valid, 1);
    chk("bp_next_acc", acc_s(), 2);
    chk("bp_next_cnt", beat_cnt, 1);
    $display("backpressure next result acc=%0d cnt=%0d", acc_s(), beat_cnt);
    tick();
    chk("bp_drain", out_valid, 0);

    // Beat counter saturation
    for (int c = 0; c < 300; c++) begin drive(0, 0, 0, 1); tick(); end
    drive(7, 0, 1, 1); tick(); drive(0, 0, 0, 0);
    chk("cnt_sat", beat_cnt, 255);
    chk("cnt_sat_acc", acc_s(), 7);
    $display("saturated count result acc=%0d cnt=%0d", acc_s(), beat_cnt);
    tick();

    // Reset mid-accumulation
    drive(10, 0, 0, 1); tick();
    drive(20, 1, 0, 1); tick();
    drive(30, 2, 0, 1); tick();
    drive(0, 0, 0, 0);
    #2 rst_n = 1'b0; #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_cnt", beat_cnt, 0);
    tick(); rst_n = 1'b1;
    drive(1, 0, 1, 1); tick(); drive(0, 0, 0, 0);
    chk("midrst_acc", acc_s(), 1);
    chk("midrst_beats", beat_cnt, 1);
    $display("post-reset result acc=%0d cnt=%0d", acc_s(), beat_cnt);

    // Reset during HOLD drops the pending result
    out_ready = 1'b0; tick();
    #2 rst_n = 1'b0; #1;
    chk("holdrst_valid", out_valid, 0);
    chk("holdrst_acc", acc_s(), 0);
    tick(); rst_n = 1'b1; out_ready = 1'b1; tick();

    // Randomised traffic against the model
    begin
      longint q[$];
      bit     ov_m = 0, err_m = 0, sat_m = 0, sat_tmp;
      longint acc_m = 0;
      int     cnt_m = 0;
      for (int c = 0; c < 500; c++) begin
        bit v, last, orr, clr, exp_rdy, take;
        int ps, sh;
        v    = ($urandom_range(0, 3) != 0);
        ps   = int'($urandom_range(0, 1023));
        if (ps >= 512) ps = ps - 1024;
        sh   = int'($urandom_range(0, 14));
        last = ($urandom_range(0, 3) == 0);
        orr  = ($urandom_range(0, 2) != 0);
        clr  = ($urandom_range(0, 15) == 0);
        drive(ps, sh, last, v);
        out_ready = orr; clr_err = clr;
        #1;
        exp_rdy = !ov_m || orr;
        chk("rnd_in_ready", in_ready, longint'(exp_rdy));
        take = v && exp_rdy;
        if (ov_m && orr) ov_m = 0;
        if (take) begin
          q.push_back(sh > MAX_SHIFT ? 0 : longint'(ps) * (longint'(1) << sh));
          if (last) begin
            acc_m = model_result(q, sat_tmp);
            sat_m = sat_tmp;
            cnt_m = (q.size() > 255) ? 255 : q.size();
            ov_m  = 1;
            q.delete();
          end
        end
        if (take && sh > MAX_SHIFT) err_m = 1;
        else if (clr) err_m = 0;
        tick();
        chk("rnd_out_valid", out_valid, longint'(ov_m));
        chk("rnd_err", err_shift, longint'(err_m));
        if (ov_m) begin
          chk("rnd_acc", acc_s(), acc_m);
          chk("rnd_cnt", beat_cnt, cnt_m);
`ifdef PE_ACC_SAT_EN
          chk("rnd_sat", acc_sat, longint'(sat_m));
`endif
          if (take && last)
            $display("rnd cycle %0d result acc=%0d cnt=%0d", c, acc_s(), beat_cnt);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pe_shift_accumulator.md
Name: pe_shift_accumulator

Overview:
Consumer end of the PE adder-tree output stream. Each cycle it takes one signed 10-bit PE_sum partial, sign-extends it, left-shifts it by the bit-slice significance tagged on the beat, and accumulates it. On the beat tagged last it presents the full-precision dot-product result through a valid/ready handshake. One instance sits after each PE adder, ahead of the output/requant stage.

Parameters:
ACC_W, 24, accumulator and result width in bits; must be >= 10 + MAX_SHIFT + 2.
SHIFT_W, 4, width of the in_shift field.
MAX_SHIFT, 12, largest legal shift value. Larger values are illegal.
CNT_W, 8, width of the beat counter.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  pe_sum beat is valid.
in_ready  output  1  accumulator can accept a beat.
pe_sum  input  10  signed partial sum from the PE adder tree.
in_shift  input  SHIFT_W  left-shift (slice significance) for this beat.
in_last  input  1  final beat of the current dot product.
out_valid  output  1  acc_out holds a completed result.
out_ready  input  1  downstream accepts the result.
acc_out  output  ACC_W  signed accumulated result.
beat_cnt  output  CNT_W  number of beats in the result presented on acc_out.
err_shift  output  1  sticky flag: a beat with in_shift > MAX_SHIFT was accepted.
clr_err  input  1  synchronous clear of err_shift.

Behaviour:
- Reset (async assert, sync release): acc=0, cnt=0, out_valid=0, acc_out=0, beat_cnt=0, err_shift=0, state=IDLE.
- Handshake: beat accepted when in_valid && in_ready. Result consumed when out_valid && out_ready. in_ready = !out_valid || out_ready. This is a combinational path from out_ready to in_ready, and it gives full throughput.
- Term: term = sext_ACC_W(pe_sum) <<< in_shift. Arithmetic is two's complement. Without the optional feature, the sum wraps modulo 2^ACC_W.
- States: IDLE (acc=0, cnt=0), ACCUM (partial sum held), HOLD (out_valid=1).
- IDLE on accepted beat with !in_last: acc<=term, cnt<=1, go to ACCUM.
- IDLE on accepted beat with in_last: single-beat result. acc_out<=term, beat_cnt<=1, out_valid<=1, go to HOLD.
- ACCUM on accepted beat: acc<=acc+term, cnt<=cnt+1.
- ACCUM with in_last: acc_out<=acc+term, beat_cnt<=cnt+1, out_valid<=1, acc<=0, cnt<=0, go to HOLD.
- ACCUM with no beat: hold all state.
- HOLD with !out_ready: hold acc_out/beat_cnt stable, in_ready=0.
- HOLD with out_ready and no beat: out_valid<=0, go to IDLE.
- HOLD with out_ready and a simultaneous beat: the beat starts a fresh accumulation, exactly as from IDLE. A new in_last re-enters HOLD with out_valid held at 1 and the new result.
- Latency: result visible the cycle after the in_last beat is accepted.
- Illegal shift: a beat with in_shift > MAX_SHIFT is still accepted but contributes 0. err_shift<=1 (sticky). in_last on that beat still closes the result, and the beat still counts in cnt.
- clr_err clears err_shift. If clr_err coincides with a new illegal beat, the set wins.
- cnt saturates at 2^CNT_W-1 and never wraps.
- Reset mid-accumulation or mid-HOLD discards the partial sum and any pending result.

Optional Feature:
Macro: PE_ACC_SAT_EN.
- Defined: each add saturates to the signed ACC_W range, i.e. +(2^(ACC_W-1)-1) or -2^(ACC_W-1). Once saturated, the sum stays clamped until the result is emitted. An extra output acc_sat is 1 alongside out_valid when any add in that result saturated.
- Undefined: the sum wraps modulo 2^ACC_W and the acc_sat port is absent.

Decomposition:
- Package pe_acc_pkg holds:
  - PE_SUM_W=10 (shared with the PE adder);
  - ACC_W/SHIFT_W/MAX_SHIFT defaults;
  - the state enum {IDLE, ACCUM, HOLD};
  - a function sext_shift(pe_sum, shift) returning the ACC_W term, or 0 when the shift is illegal.
- One sub-module is natural: pe_acc_term, the combinational sign-extend/shift/legality check. The FSM and registers stay in the top module.

Test Plan:
- Single beat: pe_sum=10'sh3FF (-1), shift=4, last=1, out_ready=1 -> next cycle acc_out=-16, beat_cnt=1, out_valid pulses for one cycle.
- Four beats, shifts 0/2/4/6 with pe_sum=5,-3,7,1, last on the 4th -> acc_out=5-12+112+64=169, beat_cnt=4.
- Back-pressure: result ready with out_ready=0 for 5 cycles -> acc_out stable, in_ready=0, no beat lost. Then out_ready=1 together with a new beat (pe_sum=2, shift=0, last=1) -> next result=2.
- Illegal shift: beat pe_sum=100, shift=13, last=1 -> acc_out=0, beat_cnt=1, err_shift=1 and stays set. clr_err=1 -> err_shift=0.
- Overflow: pe_sum=511, shift=12, repeated for 8 beats at ACC_W=24. Expected 511*4096*8 = 16744448, which exceeds the 24-bit signed max of 8388607.
  - With PE_ACC_SAT_EN: acc_out=8388607, acc_sat=1.
  - Without it: acc_out is the wrapped value 16744448-16777216 = -32768.
- Reset mid-ACCUM after 3 beats, then one beat pe_sum=1, shift=0, last=1 -> acc_out=1, beat_cnt=1.
